// File: rtl/stat_stream_calculator.sv
`default_nettype none
// ============================================================================
// Module  : stat_stream_calculator
// Purpose : Per-block max / min / mean / variance over N unsigned samples,
//           one statistic selected by a priority-encoded op mask.
// Rev     : 1.0 - initial release
// ============================================================================
module stat_stream_calculator #(
    parameter int W = 4,
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_data,
    input  logic [3:0]     op,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] out_data,
    output logic           MAX,
    output logic           MIN,
    output logic           MEAN,
    output logic           VAR
);

    localparam int LOG2N = $clog2(N);
    localparam int SW    = W + LOG2N;
    localparam int QW    = 2*W + LOG2N;
    localparam int VW    = 2*W + 2*LOG2N;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        CALC  = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [LOG2N-1:0] cnt_q,   cnt_d;
    logic [W-1:0]     max_q,   max_d;
    logic [W-1:0]     min_q,   min_d;
    logic [SW-1:0]    sum_q,   sum_d;
    logic [QW-1:0]    sumsq_q, sumsq_d;
    logic [3:0]       op_q,    op_d;
    logic [2*W-1:0]   res_q,   res_d;
    logic [3:0]       flags_q, flags_d;

    logic             w_accept;
    logic             w_first;
    logic             w_last;
    logic [2*W-1:0]   w_sq;
    logic [W-1:0]     w_mean;
    logic [VW-1:0]    w_nsumsq;
    logic [VW-1:0]    w_sum2;
    logic [VW-1:0]    w_diff;
    logic [2*W-1:0]   w_var;
    logic [3:0]       w_flags;
    logic [2*W-1:0]   w_result;

    assign w_accept = in_valid && (state_q == ACCUM);
    assign w_first  = (cnt_q == '0);
    assign w_last   = (cnt_q == LOG2N'(N-1));
    assign w_sq     = (2*W)'(in_data) * (2*W)'(in_data);

    // N*sumsq >= sum^2 always holds, so the subtraction never underflows and
    // the shifted result is bounded by the 2W-bit range.
    assign w_mean   = W'(sum_q >> LOG2N);
    assign w_nsumsq = {sumsq_q, {LOG2N{1'b0}}};
    assign w_sum2   = VW'(sum_q) * VW'(sum_q);
    assign w_diff   = w_nsumsq - w_sum2;
    assign w_var    = (2*W)'(w_diff >> (2*LOG2N));

    assign w_flags[0] = op_q[0];
    assign w_flags[1] = op_q[1] & ~op_q[0];
    assign w_flags[2] = op_q[2] & ~(|op_q[1:0]);
    assign w_flags[3] = op_q[3] & ~(|op_q[2:0]);

    assign w_result = ({(2*W){w_flags[0]}} & {{W{1'b0}}, max_q})
                    | ({(2*W){w_flags[1]}} & {{W{1'b0}}, min_q})
                    | ({(2*W){w_flags[2]}} & {{W{1'b0}}, w_mean})
                    | ({(2*W){w_flags[3]}} & w_var);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        max_d   = max_q;
        min_d   = min_q;
        sum_d   = sum_q;
        sumsq_d = sumsq_q;
        op_d    = op_q;
        res_d   = res_q;
        flags_d = flags_q;
        case (state_q)
            ACCUM: begin
                if (w_accept) begin
                    // First sample of a block overwrites instead of
                    // accumulating, so no clear cycle is needed between blocks.
                    cnt_d   = cnt_q + LOG2N'(1);
                    max_d   = (w_first || (in_data > max_q)) ? in_data : max_q;
                    min_d   = (w_first || (in_data < min_q)) ? in_data : min_q;
                    sum_d   = w_first ? SW'(in_data) : sum_q + SW'(in_data);
                    sumsq_d = w_first ? QW'(w_sq) : sumsq_q + QW'(w_sq);
                    if (w_last) begin
                        op_d    = op;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                res_d   = w_result;
                flags_d = w_flags;
                state_d = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = ACCUM;
                end
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCUM;
            cnt_q   <= '0;
            max_q   <= '0;
            min_q   <= '0;
            sum_q   <= '0;
            sumsq_q <= '0;
            op_q    <= '0;
            res_q   <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            max_q   <= max_d;
            min_q   <= min_d;
            sum_q   <= sum_d;
            sumsq_q <= sumsq_d;
            op_q    <= op_d;
            res_q   <= res_d;
            flags_q <= flags_d;
        end
    end

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == HOLD);
    assign out_data  = res_q;
    assign MAX       = flags_q[0];
    assign MIN       = flags_q[1];
    assign MEAN      = flags_q[2];
    assign VAR       = flags_q[3];

endmodule
`default_nettype wire

// File: tb/tb_stat_stream_calculator.sv
`default_nettype none
// ============================================================================
// Module  : tb_stat_stream_calculator
// Purpose : Directed self-checking bench for stat_stream_calculator (W=4, N=4).
// Rev     : 1.0 - initial release
// ============================================================================
module tb_stat_stream_calculator;

    localparam int W = 4;
    localparam int N = 4;

    logic           clk       = 1'b0;
    logic           rst_n     = 1'b0;
    logic           in_valid  = 1'b0;
    logic           in_ready;
    logic [W-1:0]   in_data   = '0;
    logic [3:0]     op        = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [2*W-1:0] out_data;
    logic           MAX, MIN, MEAN, VAR;
    wire  [3:0]     flags = {VAR, MEAN, MIN, MAX};

    int tests_run    = 0;
    int tests_failed = 0;

    stat_stream_calculator #(.W(W), .N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .MAX       (MAX),
        .MIN       (MIN),
        .MEAN      (MEAN),
        .VAR       (VAR)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Inputs change 1 time unit after a rising edge; outputs are read there too.
    task automatic send_sample(input logic [3:0] d);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 20) begin
            tests_run++;
            tests_failed++;
            $display("FAIL send_sample_timeout in_ready=%0b required=1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Noise on op before the N-th sample and after it; one idle cycle mid-block.
    task automatic send_block(input logic [3:0] a, input logic [3:0] b,
                              input logic [3:0] c, input logic [3:0] d,
                              input logic [3:0] opv);
        op = 4'b0110;
        send_sample(a);
        send_sample(b);
        in_data = 4'hF;
        @(posedge clk); #1;
        send_sample(c);
        op = opv;
        send_sample(d);
        op = ~opv;
    endtask

    task automatic wait_result(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 10) begin
            @(posedge clk); #1;
            cycles++;
        end
    endtask

    task automatic release_result;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        #12;
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 8'd0 || flags !== 4'd0) begin
            tests_failed++;
            $display("FAIL reset_state in_ready=%0b out_valid=%0b out_data=%0d flags=%b required 1/0/0/0000",
                     in_ready, out_valid, out_data, flags);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_ops;
        logic [3:0] ops [4];
        logic [7:0] exp [4];
        int cyc;
        ops = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        exp = '{8'd7, 8'd1, 8'd4, 8'd5};
        for (int i = 0; i < 4; i++) begin
            send_block(4'd3, 4'd7, 4'd1, 4'd5, ops[i]);
            tests_run++;
            if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL calc_state op=%b out_valid=%0b in_ready=%0b required 0/0",
                         ops[i], out_valid, in_ready);
            end
            wait_result(cyc);
            tests_run++;
            if (cyc != 1 || out_data !== exp[i] || flags !== ops[i]) begin
                tests_failed++;
                $display("FAIL op_select op=%b latency=%0d data=%0d flags=%b required 1/%0d/%b",
                         ops[i], cyc, out_data, flags, exp[i], ops[i]);
            end
            release_result;
        end
    endtask

    task automatic test_var_mean;
        int cyc;
        send_block(4'd0, 4'd15, 4'd0, 4'd15, 4'b1000);
        wait_result(cyc);
        tests_run++;
        if (cyc != 1 || out_data !== 8'd56 || flags !== 4'b1000) begin
            tests_failed++;
            $display("FAIL variance_0_15 latency=%0d data=%0d flags=%b required 1/56/1000",
                     cyc, out_data, flags);
        end
        release_result;
        send_block(4'd0, 4'd15, 4'd0, 4'd15, 4'b0100);
        wait_result(cyc);
        tests_run++;
        if (cyc != 1 || out_data !== 8'd7 || flags !== 4'b0100) begin
            tests_failed++;
            $display("FAIL mean_0_15 latency=%0d data=%0d flags=%b required 1/7/0100",
                     cyc, out_data, flags);
        end
        release_result;
    endtask

    task automatic test_saturated;
        logic [3:0] ops  [3];
        logic [7:0] exp  [3];
        logic [3:0] expf [3];
        int cyc;
        ops  = '{4'b1111, 4'b1100, 4'b1000};
        exp  = '{8'd15, 8'd15, 8'd0};
        expf = '{4'b0001, 4'b0100, 4'b1000};
        for (int i = 0; i < 3; i++) begin
            send_block(4'd15, 4'd15, 4'd15, 4'd15, ops[i]);
            wait_result(cyc);
            tests_run++;
            if (cyc != 1 || out_data !== exp[i] || flags !== expf[i]) begin
                tests_failed++;
                $display("FAIL saturated op=%b latency=%0d data=%0d flags=%b required 1/%0d/%b",
                         ops[i], cyc, out_data, flags, exp[i], expf[i]);
            end
            release_result;
        end
    endtask

    task automatic test_zero_op;
        int cyc;
        send_block(4'd0, 4'd15, 4'd0, 4'd15, 4'b0000);
        wait_result(cyc);
        tests_run++;
        if (cyc != 1 || out_valid !== 1'b1 || out_data !== 8'd0 || flags !== 4'b0000) begin
            tests_failed++;
            $display("FAIL zero_op latency=%0d valid=%0b data=%0d flags=%b required 1/1/0/0000",
                     cyc, out_valid, out_data, flags);
        end
        release_result;
    endtask

    task automatic test_hold_stall;
        int cyc;
        send_block(4'd3, 4'd7, 4'd1, 4'd5, 4'b0010);
        wait_result(cyc);
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            in_data  = 4'd9;
            op       = 4'b0001;
            @(posedge clk); #1;
            tests_run++;
            if (out_valid !== 1'b1 || out_data !== 8'd1 || flags !== 4'b0010 || in_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL hold_stall cycle=%0d valid=%0b data=%0d flags=%b in_ready=%0b required 1/1/0010/0",
                         i, out_valid, out_data, flags, in_ready);
            end
        end
        in_valid = 1'b0;
        release_result;
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL hold_release valid=%0b in_ready=%0b required 0/1", out_valid, in_ready);
        end
        // Samples offered during HOLD must not have entered this block.
        send_block(4'd2, 4'd4, 4'd6, 4'd8, 4'b0100);
        wait_result(cyc);
        tests_run++;
        if (cyc != 1 || out_data !== 8'd5 || flags !== 4'b0100) begin
            tests_failed++;
            $display("FAIL after_hold_mean latency=%0d data=%0d flags=%b required 1/5/0100",
                     cyc, out_data, flags);
        end
        release_result;
    endtask

    task automatic test_async_reset;
        int  cyc;
        logic seen;
        send_sample(4'd9);
        send_sample(4'd12);
        #3 rst_n = 1'b0;
        #1;
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 8'd0 || flags !== 4'd0) begin
            tests_failed++;
            $display("FAIL async_reset in_ready=%0b valid=%0b data=%0d flags=%b required 1/0/0/0000",
                     in_ready, out_valid, out_data, flags);
        end
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        send_block(4'd2, 4'd2, 4'd2, 4'd2, 4'b0001);
        wait_result(cyc);
        tests_run++;
        if (cyc != 1 || out_data !== 8'd2 || flags !== 4'b0001) begin
            tests_failed++;
            $display("FAIL post_reset_block latency=%0d data=%0d flags=%b required 1/2/0001",
                     cyc, out_data, flags);
        end
        release_result;

        // Reset while in CALC: the pending result must never appear.
        send_block(4'd3, 4'd7, 4'd1, 4'd5, 4'b0001);
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        tests_run++;
        if (seen !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_in_calc out_valid_seen=%0b required 0", seen);
        end

        // Reset while in HOLD: result withdrawn immediately.
        send_block(4'd3, 4'd7, 4'd1, 4'd5, 4'b0001);
        wait_result(cyc);
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || out_data !== 8'd0 || flags !== 4'd0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_in_hold valid=%0b data=%0d flags=%b in_ready=%0b required 0/0/0000/1",
                     out_valid, out_data, flags, in_ready);
        end
        rst_n = 1'b1;
        seen  = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        tests_run++;
        if (seen !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_in_hold_pulse out_valid_seen=%0b required 0", seen);
        end

        send_block(4'd2, 4'd2, 4'd2, 4'd2, 4'b0001);
        wait_result(cyc);
        tests_run++;
        if (cyc != 1 || out_data !== 8'd2 || flags !== 4'b0001) begin
            tests_failed++;
            $display("FAIL post_hold_reset_block latency=%0d data=%0d flags=%b required 1/2/0001",
                     cyc, out_data, flags);
        end
        release_result;
    endtask

    initial begin
        test_reset();
        test_ops();
        test_var_mean();
        test_saturated();
        test_zero_op();
        test_hold_stall();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stat_stream_calculator.md
STAT_STREAM_CALCULATOR -- requirements
Module: stat_stream_calculator

Interface
REQ-001 Parameter W, default 4: sample width in bits, 2 to 16.
REQ-002 Parameter N, default 4: samples per block, power of two, 2 to 256; LOG2N = log2(N).
REQ-003 Port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 Port in_valid, input, 1: in_data holds a valid sample.
REQ-006 Port in_ready, output, 1: block accepts a sample this cycle.
REQ-007 Port in_data, input, W: unsigned sample.
REQ-008 Port op, input, 4: operation request; op[0]=max, op[1]=min, op[2]=mean, op[3]=variance.
REQ-009 Port out_valid, output, 1: a block result is presented.
REQ-010 Port out_ready, input, 1: the consumer takes the result this cycle.
REQ-011 Port out_data, output, 2W: selected statistic, zero-extended.
REQ-012 Ports MAX, MIN, MEAN, VAR, each output, 1: one-hot flag naming the statistic in out_data.

Function
REQ-013 A sample is accepted on a rising edge where in_valid=1 and in_ready=1.
REQ-014 The FSM has states ACCUM, CALC and HOLD, and reset enters ACCUM.
REQ-015 ACCUM: in_ready=1 and out_valid=0.
- Each accepted sample updates: running max, running min, sum (W+LOG2N bits), sum of squares (2W+LOG2N bits), and the sample counter (LOG2N bits).
REQ-016 The first sample of a block loads max and min directly and overwrites sum and sum of squares, with no clear cycle between blocks.
REQ-017 Acceptance of the N-th sample latches op, wraps the counter to 0 and moves the FSM to CALC.
REQ-018 CALC lasts exactly 1 cycle with in_ready=0 and out_valid=0.
- Computes mean = sum >> LOG2N (floor).
- Computes var = (N*sumsq - sum*sum) >> (2*LOG2N) (floor of population variance).
- Intermediates are wide enough that no overflow occurs.
REQ-019 The variance result always fits in 2W bits; max, min and mean are zero-extended to 2W.
REQ-020 Selection uses fixed priority on the latched op: op[0] over op[1] over op[2] over op[3].
- MAX=op[0]; MIN=op[1]&~op[0]; MEAN=op[2]&~op[1]&~op[0]; VAR=op[3]&~op[2]&~op[1]&~op[0].
REQ-021 out_data equals the OR of each statistic masked by its flag; latched op=0 gives out_data=0, all flags 0, and a result is still delivered.
REQ-022 HOLD: out_valid=1 and in_ready=0; out_data and the flags stay stable until out_ready=1.
REQ-023 HOLD with out_ready=1 returns to ACCUM on the next edge, so the minimum spacing from N-th sample acceptance to first acceptance of the next block is 3 cycles.
REQ-024 Latency: N-th sample accepted at edge t, then out_valid=1 after edge t+1 (during cycle t+1).
REQ-025 Changes on op during ACCUM before the N-th sample, or during CALC and HOLD, have no effect on the current result.
REQ-026 in_valid=0 in ACCUM holds all accumulators and the counter.
REQ-027 out_ready outside HOLD is ignored.

Reset
REQ-028 rst_n=0 immediately forces FSM=ACCUM, in_ready=1, out_valid=0, out_data=0, MAX=MIN=MEAN=VAR=0, counter=0, and all accumulators and latched op to 0.
REQ-029 Reset mid-block discards the partial block; the first sample after release is sample 1 of a new block.
REQ-030 Reset during CALC or HOLD discards the pending result with no out_valid pulse.

Verification (W=4, N=4)
REQ-031 Samples 3,7,1,5 with op=0001, then 0010, 0100, 1000 over four blocks -> out_data = 7, 1, 4, 5 with the matching single flag high.
REQ-032 Samples 0,15,0,15, op=1000 -> out_data=56, VAR=1; same samples with op=0100 -> out_data=7, MEAN=1.
REQ-033 Samples 15,15,15,15, op=1111 -> out_data=15, MAX=1 only; op=1100 -> MEAN=1 only, out_data=15; op=1000 -> out_data=0 (zero variance).
REQ-034 out_ready=0 for 5 cycles in HOLD -> out_valid=1 and out_data constant throughout, in_ready=0, in_valid pulses ignored; out_ready=1 -> ACCUM next cycle.
REQ-035 Two samples accepted, rst_n pulsed low mid-cycle -> outputs zero asynchronously; then samples 2,2,2,2 with op=0001 -> out_data=2.
REQ-036 op=0000 block -> out_valid=1, out_data=0, all flags 0.
